// File: rtl/r4sdf_stage.sv
// Radix-4 single-delay-feedback FFT stage: three L-deep feedback delay lines feeding a
// radix-4 butterfly, with valid/sof qualification, optional /4 scaling and saturation.
module r4sdf_stage #(
  parameter int DW    = 16,
  parameter int LOG2L = 2,
  parameter int SCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 ovf
);

  localparam int L  = 1 << LOG2L;
  localparam int CW = LOG2L + 2;
  localparam logic [CW-1:0]        SOF_CNT  = CW'(3 * L);
  localparam logic signed [DW+1:0] SAT_MAX  = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SAT_MIN  = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] OUT_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] OUT_MIN  = {1'b1, {(DW-1){1'b0}}};

  function automatic logic signed [DW+1:0] ext(input logic signed [DW-1:0] a);
    return {{2{a[DW-1]}}, a};
  endfunction

  function automatic logic clips(input logic signed [DW+1:0] v);
    return (SCALE == 0) && ((v > SAT_MAX) || (v < SAT_MIN));
  endfunction

  // Floor shift by 2 when scaling, otherwise clamp into the DW-bit range.
  function automatic logic signed [DW-1:0] norm(input logic signed [DW+1:0] v);
    if (SCALE != 0) return DW'(v >>> 2);
    if (v > SAT_MAX) return OUT_MAX;
    if (v < SAT_MIN) return OUT_MIN;
    return v[DW-1:0];
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d, ccnt;
  logic                  primed_q;
  logic                  out_valid_q, out_sof_q, ovf_q;
  logic signed [DW-1:0]  out_r_q, out_i_q, out_r_d, out_i_d;
  logic [2*DW-1:0]       dl_q [3][L];

  logic [1:0]            phase;
  logic                  bfly, clip;
  logic signed [DW-1:0]  hr [3];
  logic signed [DW-1:0]  hi [3];
  logic signed [DW+1:0]  fr [4];
  logic signed [DW+1:0]  fi [4];
  logic signed [DW-1:0]  nr [4];
  logic signed [DW-1:0]  ni [4];
  logic [2*DW-1:0]       din [3];
  logic [2:0]            shift;

  always_comb begin
    ccnt  = (in_valid && in_sof) ? '0 : cnt_q;
    cnt_d = ccnt + CW'(1);
    phase = ccnt[CW-1 -: 2];
    bfly  = (phase == 2'd3);
    for (int k = 0; k < 3; k++) begin
      hr[k] = $signed(dl_q[k][L-1][2*DW-1:DW]);
      hi[k] = $signed(dl_q[k][L-1][DW-1:0]);
    end
    fr[0] = ext(hr[0]) + ext(hr[1]) + ext(hr[2]) + ext(in_r);
    fi[0] = ext(hi[0]) + ext(hi[1]) + ext(hi[2]) + ext(in_i);
    fr[1] = ext(hr[0]) + ext(hi[1]) - ext(hr[2]) - ext(in_i);
    fi[1] = ext(hi[0]) - ext(hr[1]) - ext(hi[2]) + ext(in_r);
    fr[2] = ext(hr[0]) - ext(hr[1]) + ext(hr[2]) - ext(in_r);
    fi[2] = ext(hi[0]) - ext(hi[1]) + ext(hi[2]) - ext(in_i);
    fr[3] = ext(hr[0]) - ext(hi[1]) - ext(hr[2]) + ext(in_i);
    fi[3] = ext(hi[0]) + ext(hr[1]) - ext(hi[2]) - ext(in_r);
    clip = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nr[k] = norm(fr[k]);
      ni[k] = norm(fi[k]);
      clip  = clip | clips(fr[k]) | clips(fi[k]);
    end
    // In the butterfly phase all three lines take f1..f3; otherwise only line 'phase' shifts.
    for (int k = 0; k < 3; k++) begin
      din[k]   = bfly ? {nr[k+1], ni[k+1]} : {in_r, in_i};
      shift[k] = in_valid && (bfly || (phase == 2'(k)));
    end
    case (phase)
      2'd0:    begin out_r_d = hr[0]; out_i_d = hi[0]; end
      2'd1:    begin out_r_d = hr[1]; out_i_d = hi[1]; end
      2'd2:    begin out_r_d = hr[2]; out_i_d = hi[2]; end
      default: begin out_r_d = nr[0]; out_i_d = ni[0]; end
    endcase
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (shift[k]) begin
        for (int i = L - 1; i > 0; i--) dl_q[k][i] <= dl_q[k][i-1];
        dl_q[k][0] <= din[k];
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid && (primed_q || bfly);
      out_sof_q   <= in_valid && bfly && (ccnt == SOF_CNT);
      if (in_valid) begin
        cnt_q   <= cnt_d;
        out_r_q <= out_r_d;
        out_i_q <= out_i_d;
        if (bfly) begin
          primed_q <= 1'b1;
          ovf_q    <= ovf_q | clip;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_r4sdf_stage.sv
// Bench for r4sdf_stage: three configurations checked against a frame-level radix-4 DFT model.
module tb_r4sdf_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic vld, sof;
  logic signed [15:0] dr, di;
  int sel;

  logic [2:0] iv;
  logic [2:0] ov, os, of;
  logic signed [15:0] orr [3];
  logic signed [15:0] oi [3];

  assign iv[0] = vld && (sel == 0);
  assign iv[1] = vld && (sel == 1);
  assign iv[2] = vld && (sel == 2);

  r4sdf_stage #(.DW(16), .LOG2L(0), .SCALE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_sof(sof), .in_r(dr), .in_i(di),
    .out_valid(ov[0]), .out_sof(os[0]), .out_r(orr[0]), .out_i(oi[0]), .ovf(of[0]));
  r4sdf_stage #(.DW(16), .LOG2L(2), .SCALE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_sof(sof), .in_r(dr), .in_i(di),
    .out_valid(ov[1]), .out_sof(os[1]), .out_r(orr[1]), .out_i(oi[1]), .ovf(of[1]));
  r4sdf_stage #(.DW(16), .LOG2L(1), .SCALE(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_sof(sof), .in_r(dr), .in_i(di),
    .out_valid(ov[2]), .out_sof(os[2]), .out_r(orr[2]), .out_i(oi[2]), .ovf(of[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cfg %0d, t=%0t): got %0d, expected %0d", tag, sel, $time, act, exp);
    end
  endtask

  // Reference model: frame buffer plus the three stored DFT bins from the last butterfly block.
  int  mL, mS, mcnt;
  bit  mprimed, movf;
  int  cr [64];
  int  ci [64];
  int  xr [4][16];
  int  xi [4][16];
  int  nacc, first_v;

  task automatic fit(input int v, output int y);
    if (mS != 0) y = v >>> 2;
    else if (v > 32767)  begin y = 32767;  movf = 1'b1; end
    else if (v < -32768) begin y = -32768; movf = 1'b1; end
    else y = v;
  endtask

  task automatic model_step(input bit s, input int r, input int i,
                            output bit ev, output bit es, output int er, output int ei);
    int c, m, ar, ai, tr, ti;
    int yr [4];
    int yi [4];
    c = s ? 0 : mcnt;
    cr[c] = r; ci[c] = i;
    ev = 1'b0; es = 1'b0; er = 0; ei = 0;
    if (c >= 3 * mL) begin
      m = c - 3 * mL;
      for (int k = 0; k < 4; k++) begin
        ar = 0; ai = 0;
        for (int q = 0; q < 4; q++) begin
          tr = cr[m + q * mL]; ti = ci[m + q * mL];
          // Twiddle (-j)^(q*k)
          case ((q * k) % 4)
            0: begin ar += tr; ai += ti; end
            1: begin ar += ti; ai -= tr; end
            2: begin ar -= tr; ai -= ti; end
            default: begin ar -= ti; ai += tr; end
          endcase
        end
        fit(ar, yr[k]);
        fit(ai, yi[k]);
      end
      ev = 1'b1; es = (m == 0); er = yr[0]; ei = yi[0];
      for (int k = 1; k < 4; k++) begin xr[k][m] = yr[k]; xi[k][m] = yi[k]; end
      mprimed = 1'b1;
    end else if (mprimed) begin
      ev = 1'b1;
      er = xr[c / mL + 1][c % mL];
      ei = xi[c / mL + 1][c % mL];
    end
    mcnt = (c + 1) % (4 * mL);
  endtask

  task automatic cyc(input bit v, input bit s, input int r, input int i);
    bit ev, es;
    int er, ei;
    @(negedge clk);
    vld = v; sof = s; dr = 16'(r); di = 16'(i);
    ev = 1'b0; es = 1'b0; er = 0; ei = 0;
    if (v) model_step(s, r, i, ev, es, er, ei);
    @(posedge clk);
    #1;
    chk("out_valid", int'(ov[sel]), int'(ev));
    if (ev) begin
      chk("out_sof", int'(os[sel]), int'(es));
      chk("out_r", int'(orr[sel]), er);
      chk("out_i", int'(oi[sel]), ei);
      if (first_v < 0) first_v = nacc;
    end
    chk("ovf", int'(of[sel]), int'(movf));
    if (v) nacc++;
  endtask

  task automatic do_reset(input int k, input bit vld_during);
    sel = k;
    mL = (k == 0) ? 1 : (k == 1) ? 4 : 2;
    mS = (k == 1) ? 1 : 0;
    @(negedge clk);
    rst = 1'b1; vld = vld_during; sof = 1'b0; dr = 16'sd1234; di = -16'sd77;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(ov[sel]), 0);
    chk("rst_sof", int'(os[sel]), 0);
    chk("rst_r", int'(orr[sel]), 0);
    chk("rst_i", int'(oi[sel]), 0);
    chk("rst_ovf", int'(of[sel]), 0);
    @(negedge clk);
    rst = 1'b0; vld = 1'b0;
    mcnt = 0; mprimed = 1'b0; movf = 1'b0; nacc = 0; first_v = -1;
  endtask

  function automatic int rnd(input bit full);
    logic signed [15:0] t;
    t = 16'($urandom);
    if (full) return int'(t);
    return int'($urandom_range(0, 6000)) - 3000;
  endfunction

  task automatic rand_run(input int n, input bit allow_full);
    bit v, s;
    for (int j = 0; j < n; j++) begin
      v = ($urandom % 4) != 0;
      s = v ? ((mcnt == 0) && ($urandom % 2 == 1)) : ($urandom % 2 == 1);
      cyc(v, s, rnd(allow_full && ($urandom % 4 == 0)), rnd(allow_full && ($urandom % 4 == 0)));
    end
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sof = 1'b0; dr = '0; di = '0; sel = 0;

    // 1: impulse, L=1, unscaled
    do_reset(0, 1'b0);
    cyc(1, 1, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    for (int j = 0; j < 4; j++) cyc(1, j == 0, 0, 0);

    // 2: real input 0,1,0,0
    do_reset(0, 1'b0);
    cyc(1, 1, 0, 0); cyc(1, 0, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("t2_f0_r", int'(orr[0]), 1);
    cyc(1, 1, 0, 0);
    chk("t2_f1_i", int'(oi[0]), -1);
    for (int j = 0; j < 3; j++) cyc(1, 0, 0, 0);

    // 3: constant block, L=4, scaled; first output after 12 accepted samples
    do_reset(1, 1'b0);
    for (int j = 0; j < 16; j++) cyc(1, j == 0, 100, 0);
    for (int j = 0; j < 16; j++) cyc(1, j == 0, 0, 0);
    chk("t3_latency", first_v, 12);

    // 4: saturation and sticky overflow
    do_reset(0, 1'b0);
    for (int j = 0; j < 4; j++) cyc(1, j == 0, 30000, 0);
    chk("t4_sat_r", int'(orr[0]), 32767);
    chk("t4_ovf_set", int'(of[0]), 1);
    for (int j = 0; j < 8; j++) cyc(1, 0, 0, 0);
    chk("t4_ovf_sticky", int'(of[0]), 1);

    // 5: scenario 2 with idle cycles between samples (sof on idle cycles must be ignored)
    do_reset(0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      cyc(1, j == 0, (j == 1) ? 1 : 0, 0);
      cyc(0, 1, 555, 555);
    end

    // 6: reset mid-frame (with in_valid held high), then restart on a fresh frame
    do_reset(1, 1'b0);
    for (int j = 0; j < 37; j++) cyc(1, j == 0, rnd(1'b1), rnd(1'b1));
    do_reset(1, 1'b1);
    for (int j = 0; j < 48; j++) cyc(1, j == 0, rnd(1'b1), rnd(1'b1));

    // Randomised traffic on every configuration
    do_reset(2, 1'b0);
    rand_run(400, 1'b1);
    do_reset(1, 1'b0);
    rand_run(400, 1'b1);
    do_reset(0, 1'b0);
    rand_run(200, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
